// File: rtl/p_accumulator_pkg.sv
// Shared constants for the p_accumulator post-multiplier ALU stage:
// OPMODE X/Z select codes, ALUMODE codes and the default datapath width.
package p_accumulator_pkg;

   localparam int P_WIDTH = 48;

   // X select (OPMODE[1:0]) and Z select (OPMODE[3:2]) codes; M and PCIN share 2'b01
   localparam logic [1:0] SEL_ZERO = 2'b00;
   localparam logic [1:0] SEL_M    = 2'b01;
   localparam logic [1:0] SEL_PCIN = 2'b01;
   localparam logic [1:0] SEL_P    = 2'b10;
   localparam logic [1:0] SEL_C    = 2'b11;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/p_accumulator_if.sv
// Data/control bus of the p_accumulator stage. The master modport is the
// side that supplies operands and consumes results; slave is the ALU stage.
interface p_accumulator_if #(
   parameter int WIDTH = 48
);

   logic             CEC;
   logic             CEP;
   logic [WIDTH-1:0] C;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] PCIN;
   logic [3:0]       OPMODE;
   logic             ALUMODE;
   logic             CARRYIN;
   logic [WIDTH-1:0] C_reg;
   logic [WIDTH-1:0] inter_P;
   logic [WIDTH-1:0] P;
   logic [WIDTH-1:0] PCOUT;
   logic [1:0]       CARRYOUT;

   modport master (
      output CEC, CEP, C, M, PCIN, OPMODE, ALUMODE, CARRYIN,
      input  C_reg, inter_P, P, PCOUT, CARRYOUT
   );

   modport slave (
      input  CEC, CEP, C, M, PCIN, OPMODE, ALUMODE, CARRYIN,
      output C_reg, inter_P, P, PCOUT, CARRYOUT
   );

endinterface

// File: rtl/p_accumulator_adder.sv
// Combinational WIDTH-bit adder/subtractor with optional split into two
// WIDTH/2 lanes. Subtract is Z + ~X + !cin; carries are reported as
// borrows (inverted) when subtracting. carry_o[1] is the high-lane carry
// and is only non-zero when simd_i is set.
module p_accumulator_adder
   import p_accumulator_pkg::*;
#(
   parameter int WIDTH = P_WIDTH
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] z_i,
   input  logic             sub_i,
   input  logic             carry_in_i,
   input  logic             simd_i,
   output logic [WIDTH-1:0] r_o,
   output logic [1:0]       carry_o
);

   localparam int HALF = WIDTH / 2;

   logic [WIDTH-1:0]      x_eff;
   logic                  cin_eff;
   logic [WIDTH:0]        full_sum;
   logic [HALF:0]         lo_sum;
   logic [WIDTH-HALF:0]   hi_sum;

   // full-width and per-lane sums; the high lane's carry-in is "no borrow" when subtracting
   always_comb begin
      x_eff    = sub_i ? ~x_i : x_i;
      cin_eff  = sub_i ? ~carry_in_i : carry_in_i;
      full_sum = {1'b0, z_i} + {1'b0, x_eff} + {{WIDTH{1'b0}}, cin_eff};
      lo_sum   = {1'b0, z_i[HALF-1:0]} + {1'b0, x_eff[HALF-1:0]} + {{HALF{1'b0}}, cin_eff};
      hi_sum   = {1'b0, z_i[WIDTH-1:HALF]} + {1'b0, x_eff[WIDTH-1:HALF]}
               + {{(WIDTH-HALF){1'b0}}, sub_i};
      if (simd_i) begin
         r_o     = {hi_sum[WIDTH-HALF-1:0], lo_sum[HALF-1:0]};
         carry_o = {hi_sum[WIDTH-HALF] ^ sub_i, lo_sum[HALF] ^ sub_i};
      end else begin
         r_o     = full_sum[WIDTH-1:0];
         carry_o = {1'b0, full_sum[WIDTH] ^ sub_i};
      end
   end

endmodule

// File: rtl/p_accumulator.sv
// p_accumulator: 48-bit post-multiplier ALU/accumulator stage of the PIRDSP
// slice. Registers C, selects X/Z operands, adds/subtracts with carry-in and
// optionally registers the result. CREG/PREG (and USE_SIMD when the
// TWO24_EN macro is defined) are loaded through the serial config chain.
module p_accumulator
   import p_accumulator_pkg::*;
#(
   parameter logic input_freezed = 1'b0,
   parameter int   WIDTH         = P_WIDTH
) (
   input  logic            clk,
   input  logic            RSTP,
   input  logic            RSTC,
   p_accumulator_if.slave  bus,
   input  logic            configuration_input,
   input  logic            configuration_enable,
   output logic            configuration_output
);

   logic             creg_q;
   logic             preg_q;
   logic             use_simd;
   logic [WIDTH-1:0] c_d, c_q;
   logic [WIDTH-1:0] p_d, p_q;
   logic [1:0]       carry_d, carry_q;
   logic [WIDTH-1:0] m_eff, pcin_eff, c_sel, x_op, z_op;

`ifdef TWO24_EN
   logic simd_q;

   // configuration chain: input -> CREG -> PREG -> USE_SIMD -> output
   always_ff @(posedge clk) begin
      if (configuration_enable) begin
         creg_q <= configuration_input;
         preg_q <= creg_q;
         simd_q <= preg_q;
      end
   end

   assign configuration_output = simd_q;
   assign use_simd             = simd_q;
`else
   // configuration chain: input -> CREG -> PREG -> output
   always_ff @(posedge clk) begin
      if (configuration_enable) begin
         creg_q <= configuration_input;
         preg_q <= creg_q;
      end
   end

   assign configuration_output = preg_q;
   assign use_simd             = 1'b0;
`endif

   assign m_eff    = input_freezed ? '0 : bus.M;
   assign pcin_eff = input_freezed ? '0 : bus.PCIN;
   assign c_d      = bus.C;

   // C register, reset has priority over enable
   always_ff @(posedge clk) begin
      if (RSTC) begin
         c_q <= '0;
      end else if (bus.CEC) begin
         c_q <= c_d;
      end
   end

   // operand selection; feedback always comes from p_q
   always_comb begin
      c_sel = (creg_q | input_freezed) ? c_q : bus.C;
      case (bus.OPMODE[1:0])
         SEL_ZERO: x_op = '0;
         SEL_M:    x_op = m_eff;
         SEL_P:    x_op = p_q;
         default:  x_op = c_sel;
      endcase
      case (bus.OPMODE[3:2])
         SEL_ZERO: z_op = '0;
         SEL_PCIN: z_op = pcin_eff;
         SEL_P:    z_op = p_q;
         default:  z_op = c_sel;
      endcase
   end

   p_accumulator_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .x_i        (x_op),
      .z_i        (z_op),
      .sub_i      (bus.ALUMODE == ALU_SUB),
      .carry_in_i (bus.CARRYIN),
      .simd_i     (use_simd),
      .r_o        (p_d),
      .carry_o    (carry_d)
   );

   // P and CARRYOUT registers, reset wins over enable
   always_ff @(posedge clk) begin
      if (RSTP) begin
         p_q     <= '0;
         carry_q <= '0;
      end else if (bus.CEP) begin
         p_q     <= p_d;
         carry_q <= carry_d;
      end
   end

   // output selection between registered and combinational result
   always_comb begin
      bus.C_reg    = c_sel;
      bus.inter_P  = p_d;
      bus.P        = (preg_q | input_freezed) ? p_q : p_d;
      bus.PCOUT    = bus.P;
      bus.CARRYOUT = (preg_q | input_freezed) ? carry_q : carry_d;
   end

endmodule

// File: tb/tb_p_accumulator.sv
// Self-checking bench for p_accumulator. Expected {CARRYOUT,P} values are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// DUT output is sampled. SIMD checks are built only with TWO24_EN.
module tb_p_accumulator;
   import p_accumulator_pkg::*;

   localparam int W = P_WIDTH;
   localparam int H = W / 2;

   logic clk = 1'b0;
   logic RSTP, RSTC, cfg_in, cfg_en, cfg_out;

   always #5 clk = ~clk;

   p_accumulator_if #(.WIDTH(W)) bus();

   p_accumulator #(
      .input_freezed (1'b0),
      .WIDTH         (W)
   ) dut (
      .clk                  (clk),
      .RSTP                 (RSTP),
      .RSTC                 (RSTC),
      .bus                  (bus),
      .configuration_input  (cfg_in),
      .configuration_enable (cfg_en),
      .configuration_output (cfg_out)
   );

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   logic [W+1:0] exp_q[$];
   logic         exp_cfg_q[$];
   logic [W+1:0] exp_v;
   logic [2:0]   sh;

   // arithmetic reference: {carry[1:0], result}; borrow falls out of the 49-bit difference
   function automatic logic [W+1:0] model(input logic [W-1:0] z, input logic [W-1:0] x,
                                          input logic sub, input logic cin, input logic simd);
      logic [W:0] f;
      logic [H:0] lo, hi;
      if (!simd) begin
         if (sub) f = {1'b0, z} - {1'b0, x} - {{W{1'b0}}, cin};
         else     f = {1'b0, z} + {1'b0, x} + {{W{1'b0}}, cin};
         return {1'b0, f[W], f[W-1:0]};
      end
      if (sub) begin
         lo = {1'b0, z[H-1:0]} - {1'b0, x[H-1:0]} - {{H{1'b0}}, cin};
         hi = {1'b0, z[W-1:H]} - {1'b0, x[W-1:H]};
      end else begin
         lo = {1'b0, z[H-1:0]} + {1'b0, x[H-1:0]} + {{H{1'b0}}, cin};
         hi = {1'b0, z[W-1:H]} + {1'b0, x[W-1:H]};
      end
      return {hi[H], lo[H], hi[H-1:0], lo[H-1:0]};
   endfunction

   function automatic logic cfg_pred();
`ifdef TWO24_EN
      return sh[2];
`else
      return sh[1];
`endif
   endfunction

   task automatic shift_bit(input logic b);
      @(negedge clk);
      cfg_en = 1'b1;
      cfg_in = b;
      sh     = {sh[1:0], b};
      @(posedge clk);
      #1;
      cfg_en = 1'b0;
   endtask

   // always shifts three bits so the last two land in PREG/CREG in either build
   task automatic set_cfg(input logic creg, input logic preg, input logic simd);
      bus.CEC = 1'b0;
      bus.CEP = 1'b0;
      shift_bit(simd);
      shift_bit(preg);
      shift_bit(creg);
   endtask

   task automatic test_reset();
      set_cfg(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      RSTP = 1'b1;
      RSTC = 1'b1;
      bus.C = 48'h1234_5678_9ABC;
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      RSTP = 1'b0;
      RSTC = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL reset_p: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
      checks++;
      if (bus.C_reg !== '0) begin
         errors++;
         $display("FAIL reset_creg: got %h expected 0", bus.C_reg);
      end
   endtask

   task automatic test_config();
      logic [3:0] pat;
      pat = 4'b0011;  // shifted LSB first: 1,1,0,0
      for (int i = 0; i < 4; i++) begin
         shift_bit(pat[i]);
         exp_cfg_q.push_back(cfg_pred());
         checks++;
         if (cfg_out !== exp_cfg_q[0]) begin
            errors++;
            $display("FAIL config_out[%0d]: got %b expected %b", i, cfg_out, exp_cfg_q[0]);
         end
         void'(exp_cfg_q.pop_front());
      end
   endtask

   task automatic test_comb_add();
      set_cfg(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.C = 48'd5; bus.M = 48'd7; bus.PCIN = '0;
      bus.OPMODE = 4'b1101; bus.ALUMODE = ALU_ADD; bus.CARRYIN = 1'b1;
      exp_q.push_back({2'b00, 48'd13});
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL comb_add_p: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
      checks++;
      if (bus.inter_P !== 48'd13 || bus.C_reg !== 48'd5) begin
         errors++;
         $display("FAIL comb_add_interp: got %h/%h expected 13/5", bus.inter_P, bus.C_reg);
      end
   endtask

   task automatic test_random_comb();
      logic [1:0]   codes [3];
      logic [63:0]  t;
      logic [W-1:0] x, z;
      codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         t = {$urandom(), $urandom()}; bus.C    = t[W-1:0];
         t = {$urandom(), $urandom()}; bus.M    = t[W-1:0];
         t = {$urandom(), $urandom()}; bus.PCIN = t[W-1:0];
         bus.OPMODE  = {codes[$urandom_range(0, 2)], codes[$urandom_range(0, 2)]};
         bus.ALUMODE = 1'($urandom_range(0, 1));
         bus.CARRYIN = 1'($urandom_range(0, 1));
         x = (bus.OPMODE[1:0] == 2'b00) ? '0 : (bus.OPMODE[1:0] == 2'b01) ? bus.M : bus.C;
         z = (bus.OPMODE[3:2] == 2'b00) ? '0 : (bus.OPMODE[3:2] == 2'b01) ? bus.PCIN : bus.C;
         exp_q.push_back(model(z, x, bus.ALUMODE, bus.CARRYIN, 1'b0));
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({bus.CARRYOUT, bus.P} !== exp_v || bus.inter_P !== exp_v[W-1:0]) begin
            errors++;
            $display("FAIL random_comb[%0d] op=%b alu=%b: got %h expected %h",
                     i, bus.OPMODE, bus.ALUMODE, {bus.CARRYOUT, bus.P}, exp_v);
         end
      end
   endtask

   task automatic test_subtract();
      @(negedge clk);
      bus.C = 48'd3; bus.M = 48'd5; bus.PCIN = '0;
      bus.OPMODE = 4'b1101; bus.ALUMODE = ALU_SUB; bus.CARRYIN = 1'b0;
      exp_q.push_back({2'b01, 48'hFFFF_FFFF_FFFE});
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL subtract: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
   endtask

   task automatic test_accumulate();
      set_cfg(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      RSTP = 1'b1;
      @(posedge clk);
      #1;
      RSTP = 1'b0;
      @(negedge clk);
      bus.OPMODE = 4'b1001; bus.M = 48'd1; bus.ALUMODE = ALU_ADD; bus.CARRYIN = 1'b0;
      bus.CEP = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({2'b00, 48'(i)});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({bus.CARRYOUT, bus.P} !== exp_v) begin
            errors++;
            $display("FAIL accumulate[%0d]: got %h expected %h", i, {bus.CARRYOUT, bus.P}, exp_v);
         end
      end
      @(negedge clk);
      RSTP = 1'b1;
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      RSTP = 1'b0;
      bus.CEP = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL rstp_over_cep: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      bus.C = '1; bus.OPMODE = 4'b0011; bus.ALUMODE = ALU_ADD; bus.CARRYIN = 1'b0;
      bus.CEP = 1'b1;
      exp_q.push_back({2'b00, {W{1'b1}}});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL wrap_load: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
      @(negedge clk);
      bus.OPMODE = 4'b1001; bus.M = 48'd1;
      exp_q.push_back({2'b01, {W{1'b0}}});
      @(posedge clk);
      #1;
      bus.CEP = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL wrap: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
   endtask

   task automatic test_creg_latency();
      set_cfg(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      bus.C = 48'd9; bus.M = '0; bus.CEC = 1'b1;
      bus.OPMODE = 4'b1100; bus.ALUMODE = ALU_ADD; bus.CARRYIN = 1'b0;
      exp_q.push_back({2'b00, 48'd9});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL creg_load: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
      @(negedge clk);
      bus.C = 48'd11; bus.CEC = 1'b0;
      exp_q.push_back({2'b00, 48'd9});
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.CARRYOUT, bus.P} !== exp_v) begin
         errors++;
         $display("FAIL creg_hold: got %h expected %h", {bus.CARRYOUT, bus.P}, exp_v);
      end
   endtask

`ifdef TWO24_EN
   task automatic test_simd();
      for (int s = 1; s >= 0; s--) begin
         set_cfg(1'b0, 1'b0, 1'(s));
         @(negedge clk);
         bus.C = 48'h000001_FFFFFF; bus.M = 48'd1; bus.PCIN = '0;
         bus.OPMODE = 4'b1101; bus.ALUMODE = ALU_ADD; bus.CARRYIN = 1'b0;
         exp_q.push_back((s == 1) ? {2'b01, 48'h000001_000000} : {2'b00, 48'h000002_000000});
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({bus.CARRYOUT, bus.P} !== exp_v) begin
            errors++;
            $display("FAIL simd[%0d]: got %h expected %h", s, {bus.CARRYOUT, bus.P}, exp_v);
         end
      end
   endtask
`endif

   initial begin
      RSTP = 1'b0; RSTC = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0; sh = '0;
      bus.CEC = 1'b0; bus.CEP = 1'b0; bus.C = '0; bus.M = '0; bus.PCIN = '0;
      bus.OPMODE = '0; bus.ALUMODE = 1'b0; bus.CARRYIN = 1'b0;
      test_reset();
      test_config();
      test_comb_add();
      test_random_comb();
      test_subtract();
      test_accumulate();
      test_wrap();
      test_creg_latency();
`ifdef TWO24_EN
      test_simd();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/p_accumulator.md
Name: p_accumulator

Overview:
- 48-bit post-multiplier ALU/accumulator stage of the PIRDSP slice.
- Sits directly upstream of pattern_detection. It registers the C operand and drives C_reg to pattern_detection. It drives the unregistered ALU result as inter_P and the selected P output.
- Selects X and Z operands from the product (M), C, cascade input (PCIN) and P feedback, then adds or subtracts with carry-in.
- Mode bits CREG and PREG are loaded through the slice's serial configuration chain.

Parameters:
- input_freezed, 1'b0, forces the M and PCIN operands to zero, and forces C_reg and P to their registered versions regardless of CREG/PREG.
- WIDTH, 48, datapath width. The optional feature requires an even value.

Ports:
- clk  in  1  single clock; all registers update on its rising edge.
- RSTP  in  1  synchronous active-high reset of the P and CARRYOUT registers.
- RSTC  in  1  synchronous active-high reset of the C register.
- CEC  in  1  C register clock enable.
- CEP  in  1  P/CARRYOUT register clock enable.
- C  in  WIDTH  C operand.
- M  in  WIDTH  multiplier product, already sign-extended.
- PCIN  in  WIDTH  cascade input from the neighbouring slice.
- OPMODE  in  4  [1:0]=X select, [3:2]=Z select.
- ALUMODE  in  1  0 = add, 1 = subtract.
- CARRYIN  in  1  carry-in.
- C_reg  out  WIDTH  selected C, feeding pattern_detection.
- inter_P  out  WIDTH  combinational ALU result, feeding pattern_detection.
- P  out  WIDTH  selected P output.
- PCOUT  out  WIDTH  equals P.
- CARRYOUT  out  2  [0] full-width carry/borrow; [1] upper-lane carry (only with TWO24_EN, else 0).
- configuration_input  in  1  serial configuration in.
- configuration_enable  in  1  configuration shift enable.
- configuration_output  out  1  serial configuration out.

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high (RSTP for the P and CARRYOUT registers, RSTC for the C register). RSTP and RSTC act only on the data registers. Configuration bits have no reset.
- Configuration shift, on a clock edge with configuration_enable=1:
  - CREG <= configuration_input
  - PREG <= CREG
  - configuration_output = PREG
  - With TWO24_EN the chain extends: USE_SIMD <= PREG, and configuration_output = USE_SIMD.
- C register c_q:
  - RSTC=1: becomes 0.
  - Else if CEC=1: loads C.
  - Reset has priority over enable.
  - C_reg = (CREG | input_freezed) ? c_q : C.
- X select by OPMODE[1:0]: 00=0, 01=M, 10=p_q, 11=C_reg.
- Z select by OPMODE[3:2]: 00=0, 01=PCIN, 10=p_q, 11=C_reg.
- Feedback always uses the register p_q, including when PREG=0.
- Arithmetic, computed at WIDTH+1 bits, unsigned:
  - ALUMODE=0: R = Z + X + CARRYIN.
  - ALUMODE=1: R = Z + ~X + !CARRYIN, which equals Z - X - CARRYIN.
  - inter_P = R[WIDTH-1:0].
  - Carry flag = R[WIDTH] when adding, and ~R[WIDTH] (borrow) when subtracting.
- P register:
  - RSTP=1: p_q <= 0 and the registered carry <= 0.
  - Else if CEP=1: p_q <= inter_P and the registered carry <= the carry flag.
- P output: P = (PREG | input_freezed) ? p_q : inter_P. CARRYOUT selects between registered and combinational carry in the same way.
- Latency:
  - PREG=0: C to P takes 0 cycles (CREG=0) or 1 cycle (CREG=1).
  - PREG=1: one additional cycle.
- Accumulate (OPMODE=4'b1001 with CEP held high): p_q wraps modulo 2^WIDTH, and a carry is flagged on wrap.
- RSTP together with CEP: reset wins. Changing configuration mid-operation takes effect on the next cycle; data registers are not disturbed.

Optional Feature:
- Macro: TWO24_EN. Adds the USE_SIMD configuration bit.
- With the macro, when USE_SIMD=1:
  - The adder splits into two WIDTH/2 lanes.
  - No carry propagates from bit WIDTH/2-1 to bit WIDTH/2.
  - CARRYIN feeds the low lane only; the high lane's carry-in is 0 for add and "no borrow" for subtract.
  - CARRYOUT[0] = low-lane carry/borrow; CARRYOUT[1] = high-lane carry/borrow.
- With the macro and USE_SIMD=0: full-width behaviour, and CARRYOUT[1]=0.
- Without the macro: no USE_SIMD bit, and CARRYOUT[1] is tied to 0.

Decomposition:
- Shared package holds:
  - the OPMODE X/Z select codes (SEL_ZERO, SEL_M, SEL_P, SEL_C, SEL_PCIN);
  - the ALUMODE codes (ALU_ADD, ALU_SUB);
  - the datapath width constant (48).
- One sub-module: p_accumulator_adder. It is the combinational WIDTH+1 adder/subtractor with optional lane split, producing R and the lane carries.

Test Plan:
- Configuration: shift in 1,1 with configuration_enable=1 → CREG=1, PREG=1. Then shift in 0 twice → configuration_output returns the shifted bits in order 1,1 (CREG bit first out after two further edges).
- CREG=PREG=0, OPMODE=4'b1101, ALUMODE=0, C=5, M=7, CARRYIN=1 → inter_P=P=13 in the same cycle, CARRYOUT[0]=0.
- PREG=1, OPMODE=4'b1001, M=1, CEP=1 held 4 cycles from reset → P = 1,2,3,4 on successive cycles. Assert RSTP → P=0 next cycle.
- Subtract: ALUMODE=1, Z=C=3, X=M=5, CARRYIN=0 → inter_P=48'hFFFFFFFFFFFE, CARRYOUT[0]=1 (borrow).
- Wrap: p_q=48'hFFFFFFFFFFFF, OPMODE=4'b1001, M=1, ALUMODE=0, PREG=1 → P=0, CARRYOUT[0]=1 after the edge.
- TWO24_EN, USE_SIMD=1: Z=C=48'h000001_FFFFFF, X=M=1, ALUMODE=0 → inter_P=48'h000001_000000, CARRYOUT=2'b01. With USE_SIMD=0 → inter_P=48'h000002_000000, CARRYOUT=2'b00.
